// File: rtl/fifo_bf16_add_stage_if.sv
// Operand-FIFO read port plus result valid/ready port of the bfloat16 add stage.
interface fifo_bf16_add_stage_if #(
    parameter int W = 16
);
    logic         fifo_empty;
    logic         fifo_rd;
    logic [W-1:0] fifo_rdata;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         res_invalid;

    modport master (
        input  fifo_empty, fifo_rdata, res_ready,
        output fifo_rd, res_data, res_valid, res_invalid
    );

    modport slave (
        output fifo_empty, fifo_rdata, res_ready,
        input  fifo_rd, res_data, res_valid, res_invalid
    );
endinterface

// File: rtl/fifo_bf16_add_stage.sv
// Pops two FIFO words (A then B), adds them as bfloat16-style floats, presents the sum on valid/ready.
// Define BF16_RNE_EN for round-to-nearest-even; left undefined, results are truncated toward zero.
module fifo_bf16_add_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_bf16_add_stage_if.master bus,
    output logic                  busy
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M   = MAN_W + 4;
    localparam int LZW = $clog2(M + 1);
    localparam int EW  = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {
        FETCH_A, CAP_A, FETCH_B, CAP_B, ALIGN, ADD, NORM, OUT
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic             sign_q, sign_d, zsign_q, zsign_d, sub_q, sub_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [M-1:0]     mb_q, mb_d, ms_q, ms_d;
    logic [M:0]       sum_q, sum_d;
    logic [W-1:0]     res_data_q, res_data_d;
    logic             res_invalid_q, res_invalid_d, res_valid_q, res_valid_d;

    logic             sa, sb, za, zb, a_big;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma_f, mb_f;
    logic [M-1:0]     man_a, man_b;
    logic [W-2:0]     mag_a, mag_b;

    assign sa    = op_a_q[W-1];
    assign sb    = op_b_q[W-1];
    assign ea    = op_a_q[W-2:MAN_W];
    assign eb    = op_b_q[W-2:MAN_W];
    assign ma_f  = op_a_q[MAN_W-1:0];
    assign mb_f  = op_b_q[MAN_W-1:0];
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    // exp==0 inputs become true zeros so they neither win the ordering nor contribute mantissa bits
    assign man_a = za ? '0 : {1'b1, ma_f, 3'b000};
    assign man_b = zb ? '0 : {1'b1, mb_f, 3'b000};
    assign mag_a = za ? '0 : op_a_q[W-2:0];
    assign mag_b = zb ? '0 : op_b_q[W-2:0];
    assign a_big = (mag_a >= mag_b);

    logic [EXP_W-1:0] exp_big, exp_small, exp_diff;
    logic [M-1:0]     man_small, man_shift, lost_mask;

    always_comb begin
        exp_big   = a_big ? ea : eb;
        exp_small = a_big ? eb : ea;
        man_small = a_big ? man_b : man_a;
        exp_diff  = exp_big - exp_small;
        lost_mask = '0;
        if (int'(exp_diff) >= M) begin
            man_shift = {{(M-1){1'b0}}, |man_small};
        end else begin
            lost_mask = ~({M{1'b1}} << exp_diff);
            man_shift = (man_small >> exp_diff) | {{(M-1){1'b0}}, |(man_small & lost_mask)};
        end
    end

    logic [LZW-1:0]       lz;
    logic [M-1:0]         norm_m;
    logic signed [EW-1:0] e_norm, e_fin;
    logic [MAN_W-1:0]     man_fin;

    always_comb begin
        lz = '0;
        for (int i = 0; i < M; i++) begin
            if (sum_q[i]) lz = LZW'(M - 1 - i);
        end
        if (sum_q[M]) begin
            norm_m = sum_q[M:1] | {{(M-1){1'b0}}, sum_q[0]};
            e_norm = $signed({2'b00, exp_q}) + $signed(EW'(1));
        end else begin
            norm_m = sum_q[M-1:0] << lz;
            e_norm = $signed({2'b00, exp_q}) - $signed({{(EW-LZW){1'b0}}, lz});
        end
    end

`ifdef BF16_RNE_EN
    logic             round_inc;
    logic [MAN_W+1:0] man_rnd;

    always_comb begin
        round_inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        man_rnd   = {1'b0, norm_m[M-1:3]} + {{(MAN_W+1){1'b0}}, round_inc};
        // rounding carry means the significand became 10.000..: renormalize by one
        if (man_rnd[MAN_W+1]) begin
            man_fin = man_rnd[MAN_W:1];
            e_fin   = e_norm + $signed(EW'(1));
        end else begin
            man_fin = man_rnd[MAN_W-1:0];
            e_fin   = e_norm;
        end
    end
`else
    logic [3:0] grs_unused;
    assign grs_unused = {norm_m[M-1], norm_m[2:0]};
    assign man_fin    = norm_m[M-2:3];
    assign e_fin      = e_norm;
`endif

    logic         nan_a, nan_b, inf_a, inf_b, norm_inv;
    logic [W-1:0] norm_res;

    assign nan_a = (ea == EXP_ONES) && (ma_f != '0);
    assign nan_b = (eb == EXP_ONES) && (mb_f != '0);
    assign inf_a = (ea == EXP_ONES) && (ma_f == '0);
    assign inf_b = (eb == EXP_ONES) && (mb_f == '0);

    always_comb begin
        norm_inv = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            norm_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            norm_inv = 1'b1;
        end else if (inf_a) begin
            norm_res = op_a_q;
        end else if (inf_b) begin
            norm_res = op_b_q;
        end else if (sum_q == '0) begin
            norm_res = {zsign_q, {(W-1){1'b0}}};
        end else if (e_norm[EW-1] || (e_norm == '0)) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
        end else if (e_fin >= $signed({2'b00, EXP_ONES})) begin
            norm_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            norm_res = {sign_q, e_fin[EXP_W-1:0], man_fin};
        end
    end

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        sign_d        = sign_q;
        zsign_d       = zsign_q;
        sub_d         = sub_q;
        exp_d         = exp_q;
        mb_d          = mb_q;
        ms_d          = ms_q;
        sum_d         = sum_q;
        res_data_d    = res_data_q;
        res_invalid_d = res_invalid_q;
        res_valid_d   = res_valid_q;
        case (state_q)
            FETCH_A: if (bus.fifo_rd) state_d = CAP_A;
            CAP_A: begin
                op_a_d  = bus.fifo_rdata;
                state_d = FETCH_B;
            end
            FETCH_B: if (bus.fifo_rd) state_d = CAP_B;
            CAP_B: begin
                op_b_d  = bus.fifo_rdata;
                state_d = ALIGN;
            end
            ALIGN: begin
                sign_d  = a_big ? sa : sb;
                exp_d   = exp_big;
                mb_d    = a_big ? man_a : man_b;
                ms_d    = man_shift;
                sub_d   = sa ^ sb;
                zsign_d = sa & sb;
                state_d = ADD;
            end
            ADD: begin
                sum_d   = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
                state_d = NORM;
            end
            NORM: begin
                res_data_d    = norm_res;
                res_invalid_d = norm_inv;
                res_valid_d   = 1'b1;
                state_d       = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = FETCH_A;
                end
            end
            default: state_d = FETCH_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH_A;
            op_a_q        <= '0;
            op_b_q        <= '0;
            sign_q        <= 1'b0;
            zsign_q       <= 1'b0;
            sub_q         <= 1'b0;
            exp_q         <= '0;
            mb_q          <= '0;
            ms_q          <= '0;
            sum_q         <= '0;
            res_data_q    <= '0;
            res_invalid_q <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            sign_q        <= sign_d;
            zsign_q       <= zsign_d;
            sub_q         <= sub_d;
            exp_q         <= exp_d;
            mb_q          <= mb_d;
            ms_q          <= ms_d;
            sum_q         <= sum_d;
            res_data_q    <= res_data_d;
            res_invalid_q <= res_invalid_d;
            res_valid_q   <= res_valid_d;
        end
    end

    // reads only from the fetch states, and never while reset is held
    assign bus.fifo_rd     = ~reset & ((state_q == FETCH_A) || (state_q == FETCH_B)) & ~bus.fifo_empty;
    assign bus.res_data    = res_data_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_invalid = res_invalid_q;
    assign busy            = (state_q != FETCH_A);
endmodule
